// File: rtl/turf_cin_tx.sv
// TURF-side CIN command transmitter.
// Serializes 32-bit words MSB nybble first over 8 cycles into the CIN OSERDES.
// Each word is a command, the training pattern, or the idle word.
// sync_i forces word alignment. If sync_i arrives off a word boundary, the sticky realign flag is set.
module turf_cin_tx #(
  parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
  parameter logic [31:0] IDLE_WORD      = 32'h00000000
) (
  input  logic        sysclk_i,
  input  logic        rst_n_i,
  input  logic        sync_i,
  input  logic        train_i,
  input  logic [31:0] command_i,
  input  logic        command_valid_i,
  output logic        command_ready_o,
  output logic [3:0]  cin_o,
  output logic        word_start_o,
  output logic        training_o,
  output logic        realign_o,
  input  logic        realign_clr_i,
  output logic [15:0] cmd_count_o
);

  logic [2:0]  phase_r;
  logic [31:0] sr_r;
  logic        tf_r;
  logic        ws_r;
  logic        realign_r;
  logic [15:0] cmd_count_r;

  logic        load_edge_s;
  logic        misalign_s;
  logic        ready_s;
  logic        accept_s;
  logic [2:0]  phase_nxt_s;
  logic [31:0] sr_nxt_s;
  logic        tf_nxt_s;
  logic        realign_nxt_s;

  // Word-boundary decode and the command handshake (ready held low during reset)
  always_comb begin
    load_edge_s = (phase_r == 3'd7) | sync_i;
    misalign_s  = sync_i & (phase_r != 3'd7);
    ready_s     = rst_n_i & load_edge_s & ~train_i;
    accept_s    = ready_s & command_valid_i;
  end

  // Next-state selection: load a new word at a boundary, otherwise shift out one nybble
  always_comb begin
    phase_nxt_s = phase_r;
    sr_nxt_s    = sr_r;
    tf_nxt_s    = tf_r;
    if (load_edge_s) begin
      phase_nxt_s = 3'd0;
      if (train_i) begin
        sr_nxt_s = TRAIN_SEQUENCE;
        tf_nxt_s = 1'b1;
      end else if (command_valid_i) begin
        sr_nxt_s = command_i;
        tf_nxt_s = 1'b0;
      end else begin
        sr_nxt_s = IDLE_WORD;
        tf_nxt_s = 1'b0;
      end
    end else begin
      phase_nxt_s = phase_r + 3'd1;
      sr_nxt_s    = {sr_r[27:0], 4'h0};
      tf_nxt_s    = tf_r;
    end
  end

  // Sticky realign flag: a misaligned sync wins over a same-cycle clear
  always_comb begin
    if (misalign_s) begin
      realign_nxt_s = 1'b1;
    end else if (realign_clr_i) begin
      realign_nxt_s = 1'b0;
    end else begin
      realign_nxt_s = realign_r;
    end
  end

  // State registers; reset parks the phase at 7 so the first edge after release is a load edge
  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      phase_r     <= 3'd7;
      sr_r        <= IDLE_WORD;
      tf_r        <= 1'b0;
      ws_r        <= 1'b0;
      realign_r   <= 1'b0;
      cmd_count_r <= 16'd0;
    end else begin
      phase_r   <= phase_nxt_s;
      sr_r      <= sr_nxt_s;
      tf_r      <= tf_nxt_s;
      ws_r      <= load_edge_s;
      realign_r <= realign_nxt_s;
      if (accept_s) begin
        cmd_count_r <= cmd_count_r + 16'd1;
      end else begin
        cmd_count_r <= cmd_count_r;
      end
    end
  end

  assign command_ready_o = ready_s;
  assign cin_o           = sr_r[31:28];
  assign word_start_o    = ws_r;
  assign training_o      = tf_r;
  assign realign_o       = realign_r;
  assign cmd_count_o     = cmd_count_r;

endmodule

// File: tb/tb_turf_cin_tx.sv
// Directed, table-driven bench for turf_cin_tx.
module tb_turf_cin_tx;

  localparam logic [31:0] TRAIN = 32'hA55A6996;

  logic        sysclk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        sync_i = 1'b0;
  logic        train_i = 1'b0;
  logic [31:0] command_i = 32'h0;
  logic        command_valid_i = 1'b0;
  logic        command_ready_o;
  logic [3:0]  cin_o;
  logic        word_start_o;
  logic        training_o;
  logic        realign_o;
  logic        realign_clr_i = 1'b0;
  logic [15:0] cmd_count_o;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt;

  turf_cin_tx dut (
    .sysclk_i        (sysclk_i),
    .rst_n_i         (rst_n_i),
    .sync_i          (sync_i),
    .train_i         (train_i),
    .command_i       (command_i),
    .command_valid_i (command_valid_i),
    .command_ready_o (command_ready_o),
    .cin_o           (cin_o),
    .word_start_o    (word_start_o),
    .training_o      (training_o),
    .realign_o       (realign_o),
    .realign_clr_i   (realign_clr_i),
    .cmd_count_o     (cmd_count_o)
  );

  always #5 sysclk_i = ~sysclk_i;

  typedef struct {
    logic        rst_n, sync, train, valid, clr;
    logic [31:0] cmd;
    logic        e_ready;
    logic [3:0]  e_cin;
    logic        e_ws, e_tr, e_ra;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst_n, sync, train, valid, clr, input logic [31:0] cmd,
                              input logic e_ready, input logic [3:0] e_cin,
                              input logic e_ws, e_tr, e_ra, input logic [15:0] e_cnt);
    vec_t r;
    r.rst_n = rst_n; r.sync = sync; r.train = train; r.valid = valid; r.clr = clr; r.cmd = cmd;
    r.e_ready = e_ready; r.e_cin = e_cin; r.e_ws = e_ws; r.e_tr = e_tr; r.e_ra = e_ra; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational ready, then step past the edge.
  task automatic cycle(input logic s, t, v, c, input logic [31:0] cmd, input logic er, input string nm);
    sync_i = s; train_i = t; command_valid_i = v; realign_clr_i = c; command_i = cmd;
    #1;
    chk(nm, {31'd0, command_ready_o}, {31'd0, er});
    @(posedge sysclk_i); #1;
  endtask

  // Idle until the next edge is a load edge (ready visible with train low).
  task automatic align();
    logic found;
    found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      sync_i = 1'b0; train_i = 1'b0; command_valid_i = 1'b0; realign_clr_i = 1'b0; command_i = 32'h0;
      #1;
      if (command_ready_o) found = 1'b1;
      else begin
        @(posedge sysclk_i); #1;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL align: no load edge within 16 cycles");
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  tn[8];
    logic [31:0] w[2];
    logic [31:0] word, c1, c2;
    int idx, n;
    logic v;

    tn = '{4'hA, 4'h5, 4'h5, 4'hA, 4'h6, 4'h9, 4'h9, 4'h6};

    // Reset, then training pattern
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0, 1'b0, 4'h0,1'b0,1'b0,1'b0,16'd0));
    tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0, 1'b0, 4'hA,1'b1,1'b1,1'b0,16'd0));
    for (int k = 1; k < 8; k++)
      tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0, 1'b0, tn[k],1'b0,1'b1,1'b0,16'd0));
    tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0, 1'b0, 4'hA,1'b1,1'b1,1'b0,16'd0));
    tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0, 1'b0, 4'h5,1'b0,1'b1,1'b0,16'd0));
    // Single command 12345678: training word finishes first, then one ready pulse
    for (int k = 2; k < 8; k++)
      tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,32'h12345678, 1'b0, tn[k],1'b0,1'b1,1'b0,16'd0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,32'h12345678, 1'b1, 4'h1,1'b1,1'b0,1'b0,16'd1));
    for (int k = 2; k <= 8; k++)
      tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,32'h12345678, 1'b0, 4'(k),1'b0,1'b0,1'b0,16'd1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,32'h12345678, 1'b1, 4'h0,1'b1,1'b0,1'b0,16'd1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0, 4'h0,1'b0,1'b0,1'b0,16'd1));

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n_i = tbl[i].rst_n; sync_i = tbl[i].sync; train_i = tbl[i].train;
      command_valid_i = tbl[i].valid; realign_clr_i = tbl[i].clr; command_i = tbl[i].cmd;
      #1;
      chk($sformatf("tbl%0d_ready", i), {31'd0, command_ready_o}, {31'd0, tbl[i].e_ready});
      @(posedge sysclk_i); #1;
      chk($sformatf("tbl%0d_cin", i), {28'd0, cin_o}, {28'd0, tbl[i].e_cin});
      chk($sformatf("tbl%0d_ws", i), {31'd0, word_start_o}, {31'd0, tbl[i].e_ws});
      chk($sformatf("tbl%0d_tr", i), {31'd0, training_o}, {31'd0, tbl[i].e_tr});
      chk($sformatf("tbl%0d_ra", i), {31'd0, realign_o}, {31'd0, tbl[i].e_ra});
      chk($sformatf("tbl%0d_cnt", i), {16'd0, cmd_count_o}, {16'd0, tbl[i].e_cnt});
    end
    exp_cnt = 16'd1;

    // Back-to-back commands, valid held continuously
    align();
    w[0] = 32'hDEADBEEF; w[1] = 32'hCAFEF00D; idx = 0;
    for (int i = 0; i < 16; i++) begin
      v = (idx < 2);
      sync_i = 1'b0; train_i = 1'b0; realign_clr_i = 1'b0; command_valid_i = v;
      command_i = v ? w[idx] : 32'h0;
      #1;
      chk($sformatf("b2b%0d_ready", i), {31'd0, command_ready_o}, {31'd0, (i % 8 == 0)});
      if (command_ready_o && v) idx++;
      @(posedge sysclk_i); #1;
      word = w[i / 8];
      chk($sformatf("b2b%0d_cin", i), {28'd0, cin_o}, {28'd0, word[(31 - 4 * (i % 8)) -: 4]});
    end
    exp_cnt = exp_cnt + 16'd2;
    chk("b2b_cnt", {16'd0, cmd_count_o}, {16'd0, exp_cnt});

    // Training raised mid-word; pending command accepted after train falls
    align();
    c1 = 32'h11223344; c2 = 32'h55667788;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, (i >= 4 && i < 16), (i <= 16), 1'b0, (i == 0) ? c1 : c2,
            ((i % 8 == 0) && !(i >= 4 && i < 16)), $sformatf("trn%0d_ready", i));
      word = (i / 8 == 0) ? c1 : ((i / 8 == 1) ? TRAIN : c2);
      chk($sformatf("trn%0d_cin", i), {28'd0, cin_o}, {28'd0, word[(31 - 4 * (i % 8)) -: 4]});
      chk($sformatf("trn%0d_tr", i), {31'd0, training_o}, {31'd0, (i / 8 == 1)});
    end
    exp_cnt = exp_cnt + 16'd2;
    chk("trn_cnt", {16'd0, cmd_count_o}, {16'd0, exp_cnt});

    // Misaligned sync truncates AABBCCDD at p==3
    align();
    c1 = 32'hAABBCCDD; c2 = 32'h99887766;
    cycle(1'b0, 1'b0, 1'b1, 1'b0, c1, 1'b1, "sync_load_ready");
    chk("sync_first_cin", {28'd0, cin_o}, 32'hA);
    for (int k = 1; k < 4; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "sync_mid_ready");
      chk($sformatf("sync_c1_cin%0d", k), {28'd0, cin_o}, {28'd0, c1[(31 - 4 * k) -: 4]});
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, c2, 1'b1, "sync_mis_ready");
    chk("sync_new_cin", {28'd0, cin_o}, 32'h9);
    chk("sync_new_ws", {31'd0, word_start_o}, 32'h1);
    chk("sync_ra_set", {31'd0, realign_o}, 32'h1);
    exp_cnt = exp_cnt + 16'd2;
    chk("sync_cnt", {16'd0, cmd_count_o}, {16'd0, exp_cnt});
    for (int k = 1; k < 4; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "sync_hold_ready");
      chk($sformatf("sync_c2_cin%0d", k), {28'd0, cin_o}, {28'd0, c2[(31 - 4 * k) -: 4]});
      chk("sync_ra_sticky", {31'd0, realign_o}, 32'h1);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, "clr_ready");
    chk("clr_ra", {31'd0, realign_o}, 32'h0);
    chk("clr_cin", {28'd0, cin_o}, 32'h7);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, "setwins_ready");
    chk("setwins_ra", {31'd0, realign_o}, 32'h1);
    chk("setwins_cin", {28'd0, cin_o}, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, "clr2_ready");
    chk("clr2_ra", {31'd0, realign_o}, 32'h0);
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "pre7_ready");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "sync7_ready");
    chk("sync7_ws", {31'd0, word_start_o}, 32'h1);
    chk("sync7_ra", {31'd0, realign_o}, 32'h0);

    // Preload the counter to FFFF with sync held (one load per cycle), then wrap
    n = 65535 - int'(exp_cnt);
    sync_i = 1'b1; train_i = 1'b0; command_valid_i = 1'b1; realign_clr_i = 1'b0; command_i = 32'h0F0F0F0F;
    for (int k = 0; k < n; k++) begin
      @(posedge sysclk_i); #1;
    end
    exp_cnt = 16'hFFFF;
    chk("pre_wrap_cnt", {16'd0, cmd_count_o}, {16'd0, exp_cnt});
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h87654321, 1'b1, "wrap_ready");
    exp_cnt = exp_cnt + 16'd1;
    chk("wrap_cnt", {16'd0, cmd_count_o}, {16'd0, exp_cnt});
    chk("wrap_cin", {28'd0, cin_o}, 32'h8);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "mid_ready");
    chk("mid_cin", {28'd0, cin_o}, 32'h7);

    // Reset mid-word: ready forced low, outputs cleared
    rst_n_i = 1'b0;
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0, "rst_ready");
    chk("rst_cin", {28'd0, cin_o}, 32'h0);
    chk("rst_ws", {31'd0, word_start_o}, 32'h0);
    chk("rst_tr", {31'd0, training_o}, 32'h0);
    chk("rst_ra", {31'd0, realign_o}, 32'h0);
    chk("rst_cnt", {16'd0, cmd_count_o}, 32'h0);
    rst_n_i = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "rel_ready");
    chk("rel_ws", {31'd0, word_start_o}, 32'h1);
    chk("rel_cin", {28'd0, cin_o}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/turf_cin_tx.md
Name: turf_cin_tx

Overview:
- TURF-side transmitter for the CIN serial command link; drives the 4-bit parallel nybble stream into the CIN OSERDES.
- Serializes 32-bit commands, MSB nybble first, over 8 sysclk cycles per word.
- Sends the training pattern on request so the TURFIO-side receiver can align and lock.
- Sends an idle word when no command is pending.

Parameters:
- TRAIN_SEQUENCE, 32'hA55A6996: word repeated while training. Must match the receiver's value.
- IDLE_WORD, 32'h00000000: word sent when no command is accepted. The receiver treats it as a NOP.

Ports:
- sysclk_i  in  1  link clock; all logic is in this domain.
- rst_n_i  in  1  synchronous, active-low reset.
- sync_i  in  1  marks cycle 0 of the system 16-cycle sequence; forces word alignment.
- train_i  in  1  request training pattern; level-sensitive.
- command_i  in  32  command word.
- command_valid_i  in  1  command_i is valid.
- command_ready_o  out  1  command accepted this cycle when command_valid_i is also high.
- cin_o  out  4  parallel nybble to OSERDES.
- word_start_o  out  1  high while cin_o carries bits [31:28] of a word.
- training_o  out  1  the word currently on cin_o is TRAIN_SEQUENCE.
- realign_o  out  1  sticky: sync_i arrived off-boundary; cleared by realign_clr_i.
- realign_clr_i  in  1  clears realign_o.
- cmd_count_o  out  16  count of accepted commands; wraps at 16'hFFFF -> 0.

Behaviour:
- State: 3-bit phase counter p, 32-bit shift register sr, training flag tf.
- cin_o = sr[31:28]. word_start_o = (p==0). training_o = tf.
- Load edge: an edge where p==7 OR sync_i==1.
- At a load edge:
  - p <= 0.
  - If train_i: sr <= TRAIN_SEQUENCE, tf <= 1.
  - Else if command_valid_i: sr <= command_i, tf <= 0, cmd_count_o increments.
  - Else: sr <= IDLE_WORD, tf <= 0.
- At any other edge: p <= p+1, sr <= {sr[27:0],4'h0}; tf is held.
- Latency: a word accepted at a load edge has its nybble [31:28] on cin_o in the following cycle (p==0). Nybble [3:0] appears at p==7.
- Handshake:
  - command_ready_o = load_edge & ~train_i, combinational from p, sync_i and train_i.
  - A transfer occurs only when command_ready_o & command_valid_i are both high.
  - The source must hold command_valid_i/command_i until the transfer.
  - While train_i is high, no command is accepted; the pending command waits.
- Training:
  - train_i is only sampled at load edges; words are never truncated by train_i.
  - Toggling train_i mid-word takes effect at the next word boundary.
- sync_i:
  - If high at an edge where p==7: ordinary load, no flag.
  - If high at an edge where p!=7: the word in flight is truncated (remaining nybbles are never sent), a new word loads, and realign_o <= 1.
  - A command truncated this way was already counted; it is not re-sent.
- realign_o:
  - Sticky.
  - realign_clr_i clears it unless a misaligned sync_i occurs in the same cycle; set wins.
- Reset (rst_n_i low at edge):
  - p <= 7, so the first edge after reset release is a load edge.
  - sr <= IDLE_WORD, tf <= 0, realign_o <= 0, cmd_count_o <= 0.
  - Consequently cin_o = 0, word_start_o = 0, training_o = 0 during reset.
  - command_ready_o is forced 0 while rst_n_i is low.
  - Reset mid-word discards the word.

Test Plan:
- Reset, train_i=1, no sync_i:
  - First load edge after release; cin_o then repeats A,5,5,A,6,9,9,6 every 8 cycles.
  - word_start_o high on each A; training_o=1; command_ready_o never high.
- train_i=0, command_valid_i=1, command_i=32'h12345678 held:
  - Exactly one ready pulse at a load edge; next 8 cycles cin_o = 1..8.
  - cmd_count_o=1.
  - Drop valid; following words are all 0.
- Back-to-back commands 32'hDEADBEEF, 32'hCAFEF00D, valid held continuously:
  - Ready pulses 8 cycles apart; cin_o = D,E,A,D,B,E,E,F,C,A,F,E,F,0,0,D with no gap.
  - cmd_count_o=2.
- Training toggle: raise train_i at p==3 of a command word:
  - Command completes all 8 nybbles; the next word is TRAIN_SEQUENCE.
  - A command_valid_i pending during training is accepted at the first load edge after train_i falls.
- sync_i at p==3 during command 32'hAABBCCDD:
  - cin_o shows A,A,B,B then the new word starts next cycle.
  - realign_o=1 and stays 1.
  - realign_clr_i pulse clears it.
  - sync_i at p==7 leaves realign_o=0.
- cmd_count_o preloaded by sending 65535 commands:
  - One more accepted command gives cmd_count_o=0.
  - rst_n_i low mid-word clears it and forces cin_o=0 on the next cycle.
